// File: rtl/alu_pkg.sv
// Shared ALU encodings for the issue stage and its control decoder.
//   alu_ctrl_e : 4-bit ALU operation codes driven on alu_control
//   alu_op_e   : 2-bit class from the main decoder
//   funct3_e   : funct3 values recognised under the R/I-type class
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_ILLEGAL = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BR    = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLT     = 3'b010,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_e;

endpackage

// File: rtl/alu_control_dec.sv
// Pure combinational ALU control decoder.
//   alu_op, funct3, funct7_5, is_rtype : decoded instruction fields
//   control : 4-bit ALU operation code
//   illegal : 1 when the combination is unsupported (control = 4'b1111)
module alu_control_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [3:0] control,
  output logic       illegal
);

  always_comb begin
    control = ALU_ILLEGAL;
    illegal = 1'b1;
    case (alu_op)
      ALUOP_MEM: begin
        control = ALU_ADD;
        illegal = 1'b0;
      end
      ALUOP_BR: begin
        control = ALU_SUB;
        illegal = 1'b0;
      end
      ALUOP_FUNCT: begin
        illegal = 1'b0;
        case (funct3)
          // funct7[5] only selects SUB for R-type; for ADDI it is immediate bits
          F3_ADD_SUB: control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
          F3_AND:     control = ALU_AND;
          F3_OR:      control = ALU_OR;
          F3_SLT:     control = ALU_SLT;
          default: begin
            control = ALU_ILLEGAL;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        control = ALU_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register in front of the ALU.
// Decodes the ALU control code, selects operand 2 and holds the result in a
// single-entry register with valid/ready handshake and flush.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake
//   in_*                : decoded instruction fields and operands
//   flush               : drop the held entry and any incoming transfer
//   out_valid/out_ready : downstream handshake
//   alu_in1/alu_in2/alu_control/out_illegal/out_rd/out_pc : registered entry
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_alu_op,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            in_is_rtype,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [REGW-1:0] in_rd,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_control,
  output logic [REGW-1:0] out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  logic [3:0] dec_control;
  logic       dec_illegal;
  logic       load;

  alu_control_dec u_dec (
    .alu_op   (in_alu_op),
    .funct3   (in_funct3),
    .funct7_5 (in_funct7_5),
    .is_rtype (in_is_rtype),
    .control  (dec_control),
    .illegal  (dec_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_control <= ALU_ADD;
      out_illegal <= 1'b0;
      out_rd      <= '0;
      out_pc      <= '0;
    end else begin
      // Data is not cleared on consume; it is qualified by out_valid only.
      if (load) begin
        alu_in1     <= in_rs1_data;
        alu_in2     <= in_use_imm ? in_imm : in_rs2_data;
        alu_control <= dec_control;
        out_illegal <= dec_illegal;
        out_rd      <= in_rd;
        out_pc      <= in_pc;
      end
      if (flush)          out_valid <= 1'b0;
      else if (load)      out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_alu_op;
  logic [2:0]      in_funct3;
  logic            in_funct7_5;
  logic            in_is_rtype;
  logic            in_use_imm;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [REGW-1:0] in_rd;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [3:0]      alu_control;
  logic [REGW-1:0] out_rd;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  alu_issue_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_op   (in_alu_op),
    .in_funct3   (in_funct3),
    .in_funct7_5 (in_funct7_5),
    .in_is_rtype (in_is_rtype),
    .in_use_imm  (in_use_imm),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_control (alu_control),
    .out_rd      (out_rd),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge, then let outputs settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                       input logic rt, input logic ui, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [31:0] pc);
    in_alu_op = op; in_funct3 = f3; in_funct7_5 = f75; in_is_rtype = rt;
    in_use_imm = ui; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
    in_rd = rd; in_pc = pc;
  endtask

  // decode sweep vectors: op, f3, f75, rtype, use_imm, rs1, rs2, imm, exp ctrl, exp in2, exp illegal
  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic        rt;
    logic        ui;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [3:0]  ctrl;
    logic [31:0] in2;
    logic        ill;
  } dvec_t;

  dvec_t dv[10];

  initial begin
    dv[0] = '{2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'd7,  32'd3,  32'd99, 4'b0110, 32'd3,  1'b0};
    dv[1] = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd7,  32'd3,  32'd5,  4'b0010, 32'd5,  1'b0};
    dv[2] = '{2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 32'd12, 32'd10, 32'd0,  4'b0000, 32'd10, 1'b0};
    dv[3] = '{2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 32'd1,  32'd2,  32'd0,  4'b0001, 32'd2,  1'b0};
    dv[4] = '{2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'd9,  32'd2,  32'hFFFF_FFF0, 4'b0111, 32'hFFFF_FFF0, 1'b0};
    dv[5] = '{2'b00, 3'b101, 1'b1, 1'b0, 1'b1, 32'h100, 32'd4, 32'd8,  4'b0010, 32'd8,  1'b0};
    dv[6] = '{2'b01, 3'b001, 1'b0, 1'b1, 1'b0, 32'd5,  32'd6,  32'd0,  4'b0110, 32'd6,  1'b0};
    dv[7] = '{2'b11, 3'b000, 1'b0, 1'b1, 1'b0, 32'd3,  32'd4,  32'd0,  4'b1111, 32'd4,  1'b1};
    dv[8] = '{2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 32'd3,  32'd4,  32'd0,  4'b1111, 32'd4,  1'b1};
    dv[9] = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd20, 32'd22, 32'd0,  4'b0010, 32'd22, 1'b0};
  end

  // streaming stimulus and hand-computed expectations
  logic [2:0] s_f3   [8] = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b000, 3'b111, 3'b110, 3'b010};
  logic [3:0] s_ctrl [8] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111, 4'b0010, 4'b0000, 4'b0001, 4'b0111};

  initial begin
    logic [15:0] rdy_pat;
    int unsigned sent, got, cyc;
    logic        m_valid;
    logic        acc;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);

    // reset
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_in1", alu_in1, 32'd0);
    check("rst_in2", alu_in2, 32'd0);
    check("rst_ctrl", 32'(alu_control), 32'd2);
    check("rst_illegal", 32'(out_illegal), 32'd0);
    check("rst_rd", 32'(out_rd), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // decode sweep, back-to-back with out_ready held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(dv[i].op, dv[i].f3, dv[i].f75, dv[i].rt, dv[i].ui, dv[i].rs1, dv[i].rs2,
            dv[i].imm, 5'(i + 1), 32'h400 + 32'(i * 4));
      step();
      check($sformatf("dec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("dec%0d_ctrl", i), 32'(alu_control), 32'(dv[i].ctrl));
      check($sformatf("dec%0d_in1", i), alu_in1, dv[i].rs1);
      check($sformatf("dec%0d_in2", i), alu_in2, dv[i].in2);
      check($sformatf("dec%0d_ill", i), 32'(out_illegal), 32'(dv[i].ill));
      check($sformatf("dec%0d_rd", i), 32'(out_rd), 32'(i + 1));
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // backpressure: A held for 3 stalled cycles while B waits
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hA1, 32'hA2, 32'd0, 5'd10, 32'hA000);
    in_valid = 1'b1;
    step();
    check("bp_a_valid", 32'(out_valid), 32'd1);
    drive(2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 32'hB1, 32'hB2, 32'd0, 5'd11, 32'hB000);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      step();
      check($sformatf("bp_stall%0d_pc", i), out_pc, 32'hA000);
      check($sformatf("bp_stall%0d_in1", i), alu_in1, 32'hA1);
      check($sformatf("bp_stall%0d_ctrl", i), 32'(alu_control), 32'd2);
      check($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_b_pc", out_pc, 32'hB000);
    check("bp_b_ctrl", 32'(alu_control), 32'd0);
    check("bp_b_valid", 32'(out_valid), 32'd1);
    step();
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // flush with a held entry and an incoming instruction
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hC1, 32'd0, 32'd0, 5'd12, 32'hC000);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    check("fl_c_valid", 32'(out_valid), 32'd1);
    drive(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'hD1, 32'd0, 32'd0, 5'd13, 32'hD000);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    step();
    check("fl_d_never", 32'(out_valid), 32'd0);

    // reset while stalled on a held entry
    drive(2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 32'hE1, 32'hE2, 32'd0, 5'd14, 32'hE000);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("rs_e_ctrl", 32'(alu_control), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_ctrl", 32'(alu_control), 32'd2);
    check("rs_in1", alu_in1, 32'd0);
    check("rs_in_ready", 32'(in_ready), 32'd1);

    // streaming with pseudo-random out_ready; model tracks the valid bit
    rdy_pat = 16'b1011_0010_1101_0110;
    sent = 0; got = 0; cyc = 0; m_valid = 1'b0;
    while (got < 8 && cyc < 200) begin
      out_ready = rdy_pat[cyc % 16];
      in_valid = (sent < 8);
      if (sent < 8)
        drive(2'b10, s_f3[sent], 1'b0, 1'b1, 1'b0, 32'd1 + 32'(sent * 11), 32'(sent * 3),
              32'd0, 5'(sent + 16), 32'h1000 + 32'(sent * 4));
      #1;
      check($sformatf("st%0d_in_ready", cyc), 32'(in_ready), 32'(!m_valid || out_ready));
      check($sformatf("st%0d_valid", cyc), 32'(out_valid), 32'(m_valid));
      if (m_valid && out_ready && got < 8) begin
        check($sformatf("st_out%0d_pc", got), out_pc, 32'h1000 + 32'(got * 4));
        check($sformatf("st_out%0d_in1", got), alu_in1, 32'd1 + 32'(got * 11));
        check($sformatf("st_out%0d_in2", got), alu_in2, 32'(got * 3));
        check($sformatf("st_out%0d_ctrl", got), 32'(alu_control), 32'(s_ctrl[got]));
        got++;
      end
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
        sent++;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      step();
      cyc++;
    end
    check("st_all_received", got, 32'd8);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue register that sits directly upstream of the ALU. It accepts a decoded instruction from the decode stage, generates the 4-bit ALU control code and selects the second operand. It holds the result in a single-entry pipeline register with valid/ready handshake and flush, and presents `in1`/`in2`/`alu_control` to the ALU combinationally from that register.

## Interface
Parameters:
- `XLEN`, 32, operand/PC width
- `REGW`, 5, destination register index width

Ports:
- `clk` input 1: single clock, rising edge
- `rst` input 1: reset, synchronous, active-high
- `in_valid` input 1: decode presents an instruction
- `in_ready` output 1: stage can accept this cycle
- `in_alu_op` input 2: 00 load/store, 01 branch, 10 R/I-type, 11 reserved
- `in_funct3` input 3: instruction funct3
- `in_funct7_5` input 1: instruction bit 30
- `in_is_rtype` input 1: 1 = R-type, 0 = I-type (governs SUB decode)
- `in_use_imm` input 1: 1 = operand 2 is immediate
- `in_rs1_data`, `in_rs2_data`, `in_imm` input XLEN: operands, sign-extended immediate
- `in_rd` input REGW: destination register
- `in_pc` input XLEN: instruction PC, passed through
- `flush` input 1: kill held and incoming instruction
- `out_valid` output 1: registered instruction valid
- `out_ready` input 1: downstream consumes this cycle
- `alu_in1`, `alu_in2` output XLEN: ALU operands
- `alu_control` output 4: ALU operation code
- `out_rd` output REGW, `out_pc` output XLEN: pass-through
- `out_illegal` output 1: unsupported op; `alu_control` = 4'b1111

## Operation
- Decode (combinational, on input side):
  - `alu_op`=00 gives 0010 (ADD).
  - `alu_op`=01 gives 0110 (SUB).
  - `alu_op`=10 decodes on funct3:
    - 000 gives 0110 if `in_is_rtype & in_funct7_5`, else 0010.
    - 111 gives 0000 (AND).
    - 110 gives 0001 (OR).
    - 010 gives 0111 (SLT).
  - Any other funct3 with `alu_op`=10, and `alu_op`=11, gives 1111 with illegal=1.
- Operand 2 = `in_use_imm ? in_imm : in_rs2_data`. Operand 1 = `in_rs1_data`. No width change, no sign manipulation.
- Register: one entry holding {in1, in2, control, illegal, rd, pc}.
  - `in_ready = !out_valid | out_ready` (combinational; no dependency on `in_valid`).
  - Load when `in_valid & in_ready & !flush`.
  - `out_valid` next state:
    - flush: 0
    - else load: 1
    - else `out_ready`: 0
    - else hold.
- Flush has priority over load and over hold. The entry is dropped and the incoming transfer is discarded, even if it was accepted.
- Illegal instructions propagate as a normal valid entry; the downstream stage traps. The ALU default yields 0.
- Data registers are not cleared on consume, only on reset. Data is meaningful only while `out_valid`=1.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 per cycle when `out_ready` is held at 1.
- Reset values: `out_valid`=0, `alu_in1`=0, `alu_in2`=0, `alu_control`=4'b0010, `out_illegal`=0, `out_rd`=0, `out_pc`=0. `in_ready` reads 1 during and after reset.
- `rst` mid-operation discards the held entry in the same edge and has priority over flush and load.
- Stall (`out_valid`=1, `out_ready`=0): all outputs stable; `in_ready`=0.
- Simultaneous consume and load: the entry is replaced in the same edge, with no bubble.
- Outputs are driven only from registers; there is no combinational path from `in_*` to `alu_*`.

## Structure
- Shared package `alu_pkg`:
  - ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_ILLEGAL=4'b1111
  - ALUOP_MEM=2'b00, ALUOP_BR=2'b01, ALUOP_FUNCT=2'b10
  - funct3 constants
- One sub-module is natural: `alu_control_dec`, the pure combinational decoder (alu_op, funct3, funct7_5, is_rtype) -> (control, illegal). It is reusable and separately testable.

## Test plan
- Decode sweep, back-to-back with `out_ready`=1:
  - `alu_op`=10, R-type, funct3=000, funct7_5=1, rs1=7, rs2=3 -> next cycle `alu_control`=0110, in1=7, in2=3, `out_valid`=1.
  - Same with I-type, funct7_5=1, imm=5 -> 0010, in2=5.
  - funct3 111/110/010 -> 0000/0001/0111.
- Illegal: `alu_op`=11 or funct3=001 -> `alu_control`=1111, `out_illegal`=1, `out_valid`=1.
- Backpressure: load A, hold `out_ready`=0 for 3 cycles while `in_valid`=1 with B -> A stable, `in_ready`=0. Raise `out_ready` -> B appears the next cycle with no loss or duplicate.
- Flush with `in_valid`=1 and a held entry -> next cycle `out_valid`=0. The incoming instruction never appears.
- Reset mid-stall: `rst`=1 for one cycle while holding an entry -> `out_valid`=0, `alu_control`=0010, `in_ready`=1.
- Streaming: 8 instructions with `out_ready` toggling pseudo-randomly -> the output order and contents match the input exactly, with 1-cycle latency when unstalled.
